// File: rtl/rom_sequencer.sv
// rom_sequencer: runs the credit microprograms from an external synchronous ROM against a 3-digit BCD credit.
// Optional macro ROM_SEQ_AUTOREPEAT_EN: a held command re-executes every REPEAT_DELAY cycles.
module rom_sequencer #(
    parameter int unsigned REPEAT_DELAY = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  rom_num,
    output logic [4:0]  rom_addr,
    input  logic [3:0]  rom_data,
    output logic [11:0] credit,
    output logic        overflow,
    output logic        busy,
    output logic        done,
    output logic [2:0]  fsm_state
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        DECODE   = 3'd2,
        INC      = 3'd3,
        WAIT_REL = 3'd4
    } state_t;

    state_t      state, state_n;
    logic [1:0]  sel, sel_n;
    logic [1:0]  ptr, ptr_n;
    logic [3:0]  pc, pc_n;  // pc[3] set means all eight words have executed
    logic [11:0] credit_n;
    logic        overflow_n;
    logic [3:0]  digit;
    logic [1:0]  op, arg;

    assign op        = rom_data[3:2];
    assign arg       = rom_data[1:0];
    assign busy      = (state != IDLE);
    assign fsm_state = state;

    function automatic logic [11:0] set_digit(input logic [11:0] c, input logic [1:0] idx,
                                              input logic [3:0] val);
        logic [11:0] r;
        r = c;
        case (idx)
            2'd0:    r[3:0]  = val;
            2'd1:    r[7:4]  = val;
            default: r[11:8] = val;
        endcase
        return r;
    endfunction

    always_comb begin
        case (ptr)
            2'd0:    digit = credit[3:0];
            2'd1:    digit = credit[7:4];
            default: digit = credit[11:8];
        endcase
    end

`ifdef ROM_SEQ_AUTOREPEAT_EN
    localparam int CNT_W = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             held_same;
    assign held_same = !rom_num[2] && (rom_num[1:0] == sel);
`else
    // REPEAT_DELAY only matters when auto-repeat is built in.
    if (REPEAT_DELAY == 0) begin : g_repeat_unused
    end
`endif

    always_comb begin
        state_n    = state;
        sel_n      = sel;
        ptr_n      = ptr;
        pc_n       = pc;
        credit_n   = credit;
        overflow_n = overflow;
        done       = 1'b0;
`ifdef ROM_SEQ_AUTOREPEAT_EN
        cnt_n      = '0;
`endif
        case (state)
            IDLE: begin
                if (!rom_num[2]) begin
                    sel_n   = rom_num[1:0];
                    pc_n    = 4'd0;
                    state_n = FETCH;
                end
            end
            FETCH: state_n = DECODE;
            DECODE: begin
                if (pc[3] || op == 2'b00 || op == 2'b11) begin
                    done    = 1'b1;
                    state_n = WAIT_REL;
                end else if (op == 2'b10) begin
                    credit_n   = 12'h000;
                    overflow_n = 1'b0;
                    pc_n       = pc + 4'd1;
                    state_n    = FETCH;
                end else if (arg == 2'd3) begin
                    pc_n    = pc + 4'd1;
                    state_n = FETCH;
                end else begin
                    ptr_n   = arg;
                    state_n = INC;
                end
            end
            INC: begin
                if (digit < 4'd9) begin
                    credit_n = set_digit(credit, ptr, digit + 4'd1);
                    pc_n     = pc + 4'd1;
                    state_n  = FETCH;
                end else if (ptr == 2'd2) begin
                    // carry out of hundreds saturates instead of wrapping
                    credit_n   = 12'h999;
                    overflow_n = 1'b1;
                    pc_n       = pc + 4'd1;
                    state_n    = FETCH;
                end else begin
                    credit_n = set_digit(credit, ptr, 4'd0);
                    ptr_n    = ptr + 2'd1;
                end
            end
            WAIT_REL: begin
                if (rom_num[2]) begin
                    state_n = IDLE;
                end
`ifdef ROM_SEQ_AUTOREPEAT_EN
                else if (held_same) begin
                    if (cnt == CNT_W'(REPEAT_DELAY - 1)) begin
                        pc_n    = 4'd0;
                        state_n = FETCH;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sel      <= 2'd0;
            ptr      <= 2'd0;
            pc       <= 4'd0;
            credit   <= 12'h000;
            overflow <= 1'b0;
            rom_addr <= 5'd0;
        end else begin
            state    <= state_n;
            sel      <= sel_n;
            ptr      <= ptr_n;
            pc       <= pc_n;
            credit   <= credit_n;
            overflow <= overflow_n;
            rom_addr <= {sel_n, pc_n[2:0]};
        end
    end

`ifdef ROM_SEQ_AUTOREPEAT_EN
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else       cnt <= cnt_n;
    end
`endif

endmodule

// File: tb/tb_rom_sequencer.sv
// Bench for rom_sequencer: random command stream checked against a decimal-arithmetic model via a scoreboard.
module tb_rom_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  rom_num = 3'd4;
    logic [4:0]  rom_addr;
    logic [3:0]  rom_data = 4'd0;
    logic [11:0] credit;
    logic        overflow;
    logic        busy;
    logic        done;
    logic [2:0]  fsm_state;

    localparam int ST_IDLE = 0;
    localparam int ST_INC  = 3;

    rom_sequencer dut (
        .clk(clk), .reset(reset), .rom_num(rom_num), .rom_addr(rom_addr),
        .rom_data(rom_data), .credit(credit), .overflow(overflow),
        .busy(busy), .done(done), .fsm_state(fsm_state)
    );

    // clock / ROM / cycle counter
    always #5 clk = ~clk;

    logic [3:0] rom_mem [32];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    int          exp_cyc_q[$];
    logic [12:0] exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          m_credit = 0;
    bit          m_ovf = 1'b0;
    int          mon_ec;
    logic [12:0] mon_ev;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int p10(input int a);
        return (a == 0) ? 1 : (a == 1) ? 10 : 100;
    endfunction

    function automatic int digit_of(input int c, input int k);
        return (c / p10(k)) % 10;
    endfunction

    function automatic logic [11:0] to_bcd(input int c);
        return {4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    // reference model: decimal credit, cycle cost of each word from the documented timing
    task automatic model_run(input logic [1:0] s, output int cycles);
        logic [3:0] w;
        int k, a;
        cycles = 0;
        for (int p = 0; p < 8; p++) begin
            w = rom_mem[{s, 3'(p)}];
            if (w[3:2] == 2'b00 || w[3:2] == 2'b11) break;
            cycles += 2;
            if (w[3:2] == 2'b10) begin
                m_credit = 0;
                m_ovf = 1'b0;
            end else if (w[1:0] != 2'd3) begin
                a = int'(w[1:0]);
                k = a;
                while (k <= 2 && digit_of(m_credit, k) == 9) k++;
                cycles += (k == 3) ? (3 - a) : (k - a + 1);
                if (m_credit + p10(a) > 999) begin
                    m_credit = 999;
                    m_ovf = 1'b1;
                end else begin
                    m_credit += p10(a);
                end
            end
        end
        cycles += 2;
    endtask

    // monitor: every done pulse pops one expected result
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done_unexpected actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                mon_ec = exp_cyc_q.pop_front();
                mon_ev = exp_q.pop_front();
                chk("done_cycle", cyc, mon_ec);
                chk("result_ovf_credit", int'({overflow, credit}), int'(mon_ev));
            end
        end
    end

    // driver tasks
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout actual=busy expected=idle (cycle %0d)", cyc);
        end
    endtask

    task automatic press(input logic [2:0] cmd, input int hold, input bit scramble);
        int ncyc;
        @(negedge clk);
        rom_num = cmd;
        model_run(cmd[1:0], ncyc);
        exp_cyc_q.push_back(cyc + ncyc);
        exp_q.push_back({m_ovf, to_bcd(m_credit)});
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (i == 1) chk("busy_cycle1", int'(busy), 1);
            if (i < hold) begin
                if (scramble) rom_num = 3'($urandom_range(0, 3));
            end else begin
                rom_num = 3'(4 + $urandom_range(0, 3));
            end
        end
        wait_idle();
    endtask

    task automatic load_system_rom();
        for (int i = 0; i < 32; i++) rom_mem[i] = 4'b0000;
        rom_mem[0]  = 4'b0100;
        rom_mem[8]  = 4'b0101;
        rom_mem[16] = 4'b0110;
        rom_mem[24] = 4'b1000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running expected=finished (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        load_system_rom();
        reset = 1'b1;
        rom_num = 3'd4;
        repeat (3) @(negedge clk);
        chk("reset_credit", int'(credit), 0);
        chk("reset_overflow", int'(overflow), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_rom_addr", int'(rom_addr), 0);
        chk("reset_state", int'(fsm_state), ST_IDLE);

        // press coinciding with reset must not be latched
        rom_num = 3'd0;
        @(negedge clk);
        reset = 1'b0;
        rom_num = 3'd4;
        @(negedge clk);
        chk("press_in_reset_busy", int'(busy), 0);
        chk("press_in_reset_credit", int'(credit), 0);

        press(3'd0, 1, 1'b0);
        chk("first_inc_credit", int'(credit), 'h001);

        press(3'd3, 1, 1'b0);
        repeat (9) press(3'd1, 1, 1'b0);
        repeat (9) press(3'd0, 1, 1'b0);
        press(3'd0, 1, 1'b0);
        chk("ripple_credit", int'(credit), 'h100);
        chk("ripple_overflow", int'(overflow), 0);

        repeat (8) press(3'd2, 1, 1'b0);
        repeat (9) press(3'd1, 1, 1'b0);
        repeat (9) press(3'd0, 1, 1'b0);
        press(3'd2, 1, 1'b0);
        chk("sat_credit", int'(credit), 'h999);
        chk("sat_overflow", int'(overflow), 1);
        press(3'd3, 1, 1'b0);
        chk("clr_credit", int'(credit), 0);
        chk("clr_overflow", int'(overflow), 0);

        press(3'd1, 50, 1'b0);
        chk("held_once_credit", int'(credit), 'h010);
        press(3'd1, 1, 1'b0);
        chk("second_press_credit", int'(credit), 'h020);

        // reset during the ripple of 099+1
        press(3'd3, 1, 1'b0);
        repeat (9) press(3'd1, 1, 1'b0);
        repeat (9) press(3'd0, 1, 1'b0);
        @(negedge clk);
        rom_num = 3'd0;
        repeat (3) @(negedge clk);
        chk("mid_inc_state", int'(fsm_state), ST_INC);
        rom_num = 3'd4;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_credit", int'(credit), 0);
        chk("abort_state", int'(fsm_state), ST_IDLE);
        chk("abort_busy", int'(busy), 0);
        reset = 1'b0;
        m_credit = 0;
        m_ovf = 1'b0;

        for (int n = 0; n < 40; n++) begin
            press(3'($urandom_range(0, 3)), $urandom_range(1, 6), 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // random microprograms; ROM2 has no END so the pc wrap ends it
        for (int i = 0; i < 32; i++) rom_mem[i] = 4'($urandom_range(0, 15));
        for (int i = 16; i < 24; i++) rom_mem[i] = 4'b0100;
        press(3'd3, 1, 1'b0);
        press(3'd2, 1, 1'b0);
        for (int n = 0; n < 40; n++) begin
            press(3'($urandom_range(0, 3)), $urandom_range(1, 6), 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
